// File: rtl/alu_ctrl_fsm_pkg.sv
// alu_ctrl_fsm_pkg: shared states, instruction classes, opcodes, ALUop codes and the ALU control vector
package alu_ctrl_fsm_pkg;
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_e;
  typedef enum logic [1:0] {K_ALU, K_LOAD, K_STORE, K_BRANCH} kind_e;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [3:0] ALU_R_ADD  = 4'd0;
  localparam logic [3:0] ALU_R_SUB  = 4'd1;
  localparam logic [3:0] ALU_R_XOR  = 4'd2;
  localparam logic [3:0] ALU_R_OR   = 4'd3;
  localparam logic [3:0] ALU_R_AND  = 4'd4;
  localparam logic [3:0] ALU_R_SLL  = 4'd5;
  localparam logic [3:0] ALU_R_SRL  = 4'd6;
  localparam logic [3:0] ALU_R_SRA  = 4'd7;
  localparam logic [3:0] ALU_R_SLT  = 4'd8;
  localparam logic [3:0] ALU_R_SLTU = 4'd9;
  localparam logic [3:0] ALU_I_ADDI = 4'd0;
  localparam logic [3:0] ALU_I_XORI = 4'd1;
  localparam logic [3:0] ALU_I_ORI  = 4'd2;
  localparam logic [3:0] ALU_I_ANDI = 4'd3;
  localparam logic [3:0] ALU_I_SLLI = 4'd4;
  localparam logic [3:0] ALU_I_SRAI = 4'd5;
  localparam logic [3:0] ALU_I_SRLI = 4'd6;
  localparam logic [3:0] ALU_LUI    = 4'd8;
  localparam logic [3:0] ALU_AUIPC  = 4'd9;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       sftmd;
    logic [5:0] br;
  } ctrl_t;
  function automatic logic [5:0] br_onehot(input logic [2:0] f3);
    return f3 == 3'b000 ? 6'b100000 :
           f3 == 3'b001 ? 6'b010000 :
           f3 == 3'b100 ? 6'b001000 :
           f3 == 3'b101 ? 6'b000100 :
           f3 == 3'b110 ? 6'b000010 :
           f3 == 3'b111 ? 6'b000001 : 6'b000000;
  endfunction
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: RV32I word (instr) -> ALU control vector (ctrl), instruction class (kind), illegal flag
module alu_ctrl_decode
  import alu_ctrl_fsm_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output kind_e       kind,
  output logic        illegal
);
  logic [6:0] op;
  logic [6:0] f7;
  logic [2:0] f3;
  logic       std;
  logic       alt;
  logic       unused_fields;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign std = f7 == 7'h00;
  assign alt = f7 == 7'h20;
  assign unused_fields = ^{instr[24:15], instr[11:7]};
  always_comb begin
    ctrl = '0;
    kind = K_ALU;
    illegal = 1'b0;
    case (op)
      OP_R: begin
        case (f3)
          3'b000: ctrl.alu_op = alt ? ALU_R_SUB : ALU_R_ADD;
          3'b001: ctrl.alu_op = ALU_R_SLL;
          3'b010: ctrl.alu_op = ALU_R_SLT;
          3'b011: ctrl.alu_op = ALU_R_SLTU;
          3'b100: ctrl.alu_op = ALU_R_XOR;
          3'b101: ctrl.alu_op = alt ? ALU_R_SRA : ALU_R_SRL;
          3'b110: ctrl.alu_op = ALU_R_OR;
          default: ctrl.alu_op = ALU_R_AND;
        endcase
        ctrl.sftmd = f3 == 3'b001 || f3 == 3'b101;
        illegal = !(std || (alt && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OP_I: begin
        case (f3)
          3'b001: ctrl.alu_op = ALU_I_SLLI;
          3'b100: ctrl.alu_op = ALU_I_XORI;
          3'b101: ctrl.alu_op = alt ? ALU_I_SRAI : ALU_I_SRLI;
          3'b110: ctrl.alu_op = ALU_I_ORI;
          3'b111: ctrl.alu_op = ALU_I_ANDI;
          default: ctrl.alu_op = ALU_I_ADDI;
        endcase
        ctrl.alu_src = 1'b1;
        ctrl.sftmd = f3 == 3'b001 || f3 == 3'b101;
        illegal = f3 == 3'b010 || f3 == 3'b011 || (f3 == 3'b001 && !std) || (f3 == 3'b101 && !std && !alt);
      end
      OP_LOAD: begin
        ctrl.alu_src = 1'b1;
        kind = K_LOAD;
        illegal = f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111;
      end
      OP_STORE: begin
        ctrl.alu_src = 1'b1;
        kind = K_STORE;
        illegal = f3 > 3'b010;
      end
      OP_LUI: begin
        ctrl.alu_op = ALU_LUI;
        ctrl.alu_src = 1'b1;
      end
      OP_AUIPC: begin
        ctrl.alu_op = ALU_AUIPC;
        ctrl.alu_src = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.br = br_onehot(f3);
        kind = K_BRANCH;
        illegal = br_onehot(f3) == 6'b0;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) ctrl = '0;
  end
endmodule

// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm: RV32I multi-cycle control FSM; instr_valid/instr_ready handshake in, registered ALU flags and datapath strobes out
module alu_ctrl_fsm
  import alu_ctrl_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic        branch_result,
  input  logic        mem_ready,
  output logic [3:0]  ALUop,
  output logic        ALUSrc,
  output logic        sftmd,
  output logic        Branch,
  output logic        nBranch,
  output logic        Branch_lt,
  output logic        Branch_ge,
  output logic        Branch_ltu,
  output logic        Branch_geu,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        pc_load,
  output logic        illegal
);
  state_e      state;
  logic [31:0] instr_q;
  logic [31:0] dec_in;
  ctrl_t       ctrl_q;
  ctrl_t       dec_ctrl;
  kind_e       kind_q;
  kind_e       dec_kind;
  logic        dec_illegal;
  // the incoming word is decoded in IDLE so illegal is already up during DECODE
  assign dec_in = state == S_IDLE ? instr : instr_q;
  alu_ctrl_decode u_decode (
    .instr   (dec_in),
    .ctrl    (dec_ctrl),
    .kind    (dec_kind),
    .illegal (dec_illegal)
  );
  assign {ALUop, ALUSrc, sftmd, Branch, nBranch, Branch_lt, Branch_ge, Branch_ltu, Branch_geu} = ctrl_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      instr_q     <= INSTR_NOP;
      ctrl_q      <= '0;
      kind_q      <= K_ALU;
      instr_ready <= 1'b1;
      MemRead     <= 1'b0;
      MemWrite    <= 1'b0;
      RegWrite    <= 1'b0;
      MemtoReg    <= 1'b0;
      pc_load     <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      pc_load <= 1'b0;
      case (state)
        S_IDLE: if (instr_valid && instr_ready) begin
          instr_q     <= instr;
          illegal     <= dec_illegal;
          instr_ready <= 1'b0;
          state       <= S_DECODE;
        end
        S_DECODE: begin
          illegal <= 1'b0;
          if (illegal) begin
            instr_ready <= 1'b1;
            state       <= S_IDLE;
          end else begin
            ctrl_q <= dec_ctrl;
            kind_q <= dec_kind;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (kind_q == K_BRANCH) begin
            pc_load     <= branch_result;
            ctrl_q      <= '0;
            instr_ready <= 1'b1;
            state       <= S_IDLE;
          end else if (kind_q == K_ALU) begin
            RegWrite <= 1'b1;
            state    <= S_WB;
          end else begin
            MemRead  <= kind_q == K_LOAD;
            MemWrite <= kind_q == K_STORE;
            state    <= S_MEM;
          end
        end
        S_MEM: if (mem_ready) begin
          MemRead  <= 1'b0;
          MemWrite <= 1'b0;
          if (kind_q == K_LOAD) begin
            RegWrite <= 1'b1;
            MemtoReg <= 1'b1;
            state    <= S_WB;
          end else begin
            ctrl_q      <= '0;
            instr_ready <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_WB: begin
          RegWrite    <= 1'b0;
          MemtoReg    <= 1'b0;
          ctrl_q      <= '0;
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end
        default: begin
          ctrl_q      <= '0;
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/alu_ctrl_fsm.md
ALU_CTRL_FSM -- requirements
Module: alu_ctrl_fsm

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 instr_valid  input  1  instruction word offered.
REQ-004 instr_ready  output  1  FSM can accept an instruction; high only in IDLE.
REQ-005 instr  input  32  RV32I instruction word.
REQ-006 branch_result  input  1  ALU branch comparison result, sampled in EXEC.
REQ-007 mem_ready  input  1  data memory completion for the current access.
REQ-008 ALUop  output  4  ALU operation code.
REQ-009 ALUSrc, sftmd, Branch, nBranch, Branch_lt, Branch_ge, Branch_ltu, Branch_geu  output  1 each  ALU control flags.
REQ-010 MemRead, MemWrite, RegWrite, MemtoReg, pc_load, illegal  output  1 each  datapath strobes.

Function
REQ-011 States SHALL be IDLE, DECODE, EXEC, MEM, WB.
REQ-012 An instruction SHALL be accepted and latched when instr_valid and instr_ready are both high in IDLE; next state DECODE.
REQ-013 DECODE SHALL register all ALU control outputs from the latched word; they SHALL be held constant from EXEC through the last state of the instruction and SHALL be all-zero in IDLE and DECODE.
REQ-014 R-type (0110011) SHALL map to ALUop: add 0, sub 1, xor 2, or 3, and 4, sll 5, srl 6, sra 7, slt 8, sltu 9; ALUSrc=0; sftmd=1 only for sll/srl/sra.
REQ-015 I-ALU (0010011) SHALL map addi 0, xori 1, ori 2, andi 3, slli 4, srai 5, srli 6; ALUSrc=1; sftmd=1 only for shifts. slti/sltiu SHALL be illegal.
REQ-016 Load (0000011) and store (0100011) SHALL use ALUop 0, ALUSrc=1; lui SHALL use ALUop 8, auipc ALUop 9, both ALUSrc=1.
REQ-017 Branches (1100011) SHALL use ALUop 0, ALUSrc=0, and assert exactly one flag: beq→Branch, bne→nBranch, blt→Branch_lt, bge→Branch_ge, bltu→Branch_ltu, bgeu→Branch_geu. funct3 010/011 SHALL be illegal.
REQ-018 Sequences: ALU/lui/auipc DECODE→EXEC→WB→IDLE; load DECODE→EXEC→MEM→WB→IDLE; store DECODE→EXEC→MEM→IDLE; branch DECODE→EXEC→IDLE.
REQ-019 MEM SHALL hold MemRead (load) or MemWrite (store) high and remain in MEM until mem_ready=1; mem_ready outside MEM SHALL be ignored.
REQ-020 WB SHALL assert RegWrite for one cycle; MemtoReg=1 in WB for loads only.
REQ-021 pc_load SHALL pulse for one cycle on the EXEC→IDLE transition of a branch iff branch_result=1 in EXEC.
REQ-022 Any unsupported opcode/funct SHALL pulse illegal for one cycle in DECODE, return to IDLE, and assert no strobe.
REQ-023 RegWrite, MemWrite, MemRead SHALL never be high outside WB/MEM respectively.

Reset
REQ-024 rst_n low SHALL force IDLE immediately, at any state including MEM wait; every output SHALL be 0 except instr_ready, which SHALL be 1 after release.
REQ-025 The latched instruction register SHALL reset to 0x00000013 (nop).

Structure
REQ-026 State encoding, opcode constants, and ALUop codes SHALL live in a shared package used also by the ALU.
REQ-027 Combinational decode SHALL be one sub-module, alu_ctrl_decode (instr → control vector + illegal); the FSM module SHALL register its output.

Verification
REQ-028 instr=0x002081B3 (add) → ALUop=0, ALUSrc=0, RegWrite high exactly 3 cycles after accept, instr_ready back next cycle.
REQ-029 instr=0x402081B3 (sub) → ALUop=1 held in EXEC and WB; sftmd=0.
REQ-030 instr=0x00208463 (beq), branch_result=1 in EXEC → Branch=1, pc_load one-cycle pulse, no RegWrite; repeat with branch_result=0 → no pc_load.
REQ-031 instr=0x0000A283 (lw), mem_ready delayed 3 cycles → MemRead high 4 cycles, then WB with RegWrite=MemtoReg=1.
REQ-032 instr=0x0020A223 (sw) with rst_n pulsed low during MEM → immediate IDLE, MemWrite=0, instr_ready=1 after release.
REQ-033 instr=0xFFFFFFFF → illegal pulse in DECODE, all strobes 0, back to IDLE.
